lcd_frame_scheduler: RTL and testbench



---
 rtl/lcd_frame_scheduler.sv | 151 +++++++++++++++
 tb/tb_lcd_frame_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_scheduler.sv
// Shadow 16x2 LCD frame buffer that streams dirty cells round-robin to the character driver; start pulse two edges after the IDLE pick.
// Stalls in IDLE while lcd_ready is low; LCD_PERIODIC_REFRESH_EN adds a free-running counter that re-dirties the whole screen.
module lcd_frame_scheduler #(
  parameter int BUSY_TIMEOUT   = 16,
  parameter int REFRESH_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       lcd_ready,
  output logic       lcd_start,
  output logic [6:0] lcd_pos,
  output logic [7:0] lcd_char,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [7:0]      cell_q [32];
  logic [7:0]      cell_d [32];
  logic [31:0]     dirty_q, dirty_d;
  logic [4:0]      ptr_q, ptr_d;
  logic [4:0]      idx_q, idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            lcd_start_q, lcd_start_d;
  logic [6:0]      lcd_pos_q, lcd_pos_d;
  logic [7:0]      lcd_char_q, lcd_char_d;
  logic            busy_q, busy_d;
  logic            refresh_hit;
  logic            sel_found;
  logic [4:0]      sel_idx;

`ifdef LCD_PERIODIC_REFRESH_EN
  logic [31:0] refresh_q, refresh_d;

  always_comb begin
    refresh_hit = (refresh_q == 32'(REFRESH_CYCLES - 1));
    refresh_d   = refresh_hit ? 32'd0 : refresh_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) refresh_q <= 32'd0;
    else     refresh_q <= refresh_d;
  end
`else
  localparam int unused_refresh_cycles = REFRESH_CYCLES;
  assign refresh_hit = 1'b0;
`endif

  // Descending scan so the smallest offset from ptr is the one that sticks.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    for (int i = 31; i >= 0; i--) begin
      if (dirty_q[ptr_q + 5'(i)]) begin
        sel_found = 1'b1;
        sel_idx   = ptr_q + 5'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cell_d      = cell_q;
    dirty_d     = dirty_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    lcd_start_d = 1'b0;
    lcd_pos_d   = lcd_pos_q;
    lcd_char_d  = lcd_char_q;
    busy_d      = (dirty_q != 32'd0) || (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (lcd_ready && sel_found) begin
          idx_d            = sel_idx;
          lcd_pos_d        = {sel_idx[4], 2'b00, sel_idx[3:0]};
          lcd_char_d       = cell_q[sel_idx];
          dirty_d[sel_idx] = 1'b0;
          ptr_d            = sel_idx + 5'd1;
          state_d          = SEND;
        end
      end
      SEND: begin
        lcd_start_d = 1'b1;
        tmo_d       = '0;
        state_d     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!lcd_ready) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          // Driver never acknowledged: put the cell back in the queue.
          dirty_d[idx_q] = 1'b1;
          state_d        = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (lcd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Applied after the IDLE clear so a same-cycle write keeps the cell dirty.
    if (wr_en) begin
      cell_d[wr_addr]  = wr_data;
      dirty_d[wr_addr] = 1'b1;
    end
    if (refresh_hit) dirty_d = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < 32; i++) cell_q[i] <= 8'h20;
      dirty_q     <= '1;
      ptr_q       <= 5'd0;
      idx_q       <= 5'd0;
      tmo_q       <= '0;
      lcd_start_q <= 1'b0;
      lcd_pos_q   <= 7'h00;
      lcd_char_q  <= 8'h20;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cell_q      <= cell_d;
      dirty_q     <= dirty_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      lcd_start_q <= lcd_start_d;
      lcd_pos_q   <= lcd_pos_d;
      lcd_char_q  <= lcd_char_d;
      busy_q      <= busy_d;
    end
  end

  assign lcd_start = lcd_start_q;
  assign lcd_pos   = lcd_pos_q;
  assign lcd_char  = lcd_char_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed + randomized bench for lcd_frame_scheduler with a simple LCD driver model.
module tb_lcd_frame_scheduler;

  localparam int BUSY_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       lcd_ready;
  logic       lcd_start;
  logic [6:0] lcd_pos;
  logic [7:0] lcd_char;
  logic       busy;

  logic drv_ready, ready_en, drv_ignore;
  assign lcd_ready = drv_ready & ready_en;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [14:0] mon_q [$];
  int          mon_t [$];
  logic [14:0] exp_q [$];
  logic [7:0]  ref_buf [32];
  logic [31:0] ref_dirty;
  int          ref_ptr;

  lcd_frame_scheduler #(.BUSY_TIMEOUT(BUSY_TIMEOUT), .REFRESH_CYCLES(2000)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .lcd_ready(lcd_ready), .lcd_start(lcd_start), .lcd_pos(lcd_pos),
    .lcd_char(lcd_char), .busy(busy)
  );

  always #10 clk = ~clk;

  // Monitor: record every start pulse with its position, character and cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst && lcd_start === 1'b1) begin
      mon_q.push_back({lcd_pos, lcd_char});
      mon_t.push_back(cyc);
    end
  end

  // Driver model: ready drops two cycles after the start edge, for 10 cycles.
  initial begin
    drv_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && lcd_start === 1'b1 && !drv_ignore) begin
        @(negedge clk);
        drv_ready = 1'b0;
        repeat (10) @(negedge clk);
        drv_ready = 1'b1;
      end
    end
  end

  function automatic logic [14:0] ent(input int idx, input logic [7:0] ch);
    logic [4:0] i5;
    i5 = idx[4:0];
    return {i5[4], 2'b00, i5[3:0], ch};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic write_cell(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a[4:0];
    wr_data = d;
    ref_buf[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_within_budget", 32'(k < budget), 32'd1);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k;
    k = 0;
    while (mon_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("pulses_within_budget", 32'(k < budget), 32'd1);
  endtask

  initial begin
    int n, a, last, c;
    logic [7:0] d;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    ready_en = 1'b1; drv_ignore = 1'b0;
    for (int i = 0; i < 32; i++) ref_buf[i] = 8'h20;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(lcd_start), 32'd0);
    chk("rst_pos",   32'(lcd_pos),   32'h00);
    chk("rst_char",  32'(lcd_char),  32'h20);
    chk("rst_busy",  32'(busy),      32'd0);

    // Blank sequence after reset release
    rst = 1'b0;
    @(negedge clk);
    chk("busy_after_release", 32'(busy), 32'd1);
    chk("no_start_yet", 32'(lcd_start), 32'd0);
    @(negedge clk);
    chk("first_start", 32'(lcd_start), 32'd1);
    wait_idle(2000);
    chk("blank_count", 32'(mon_q.size()), 32'd32);
    for (int i = 0; i < 32; i++) chk($sformatf("blank_%0d", i), 32'(mon_q[i]), 32'(ent(i, 8'h20)));
    mon_q.delete(); mon_t.delete();

    // Single write
    write_cell(17, 8'h41);
    @(negedge clk);
    chk("single_busy", 32'(busy), 32'd1);
    wait_idle(200);
    chk("single_count", 32'(mon_q.size()), 32'd1);
    chk("single_ent", 32'(mon_q[0]), 32'h41_41 & 32'h7fff);
    mon_q.delete(); mon_t.delete();

    // Round-robin from ptr=5
    write_cell(4, 8'h34);
    wait_idle(200);
    mon_q.delete(); mon_t.delete();
    ready_en = 1'b0;
    write_cell(3, 8'h33);
    write_cell(9, 8'h39);
    ready_en = 1'b1;
    wait_idle(300);
    chk("rr_count", 32'(mon_q.size()), 32'd2);
    chk("rr_first",  32'(mon_q[0]), 32'(ent(9, 8'h39)));
    chk("rr_second", 32'(mon_q[1]), 32'(ent(3, 8'h33)));
    mon_q.delete(); mon_t.delete();

    // Same-cycle write to the cell being latched
    ready_en = 1'b0;
    write_cell(2, 8'h20);
    ready_en = 1'b1;
    write_cell(2, 8'h58);
    wait_idle(300);
    chk("conf_count", 32'(mon_q.size()), 32'd2);
    chk("conf_old", 32'(mon_q[0]), 32'(ent(2, 8'h20)));
    chk("conf_new", 32'(mon_q[1]), 32'(ent(2, 8'h58)));
    mon_q.delete(); mon_t.delete();
    ref_ptr = 3;

    // Randomized batches accumulated while the driver is not ready
    for (int r = 0; r < 5; r++) begin
      ref_dirty = '0;
      ready_en = 1'b0;
      n = $urandom_range(1, 12);
      for (int w = 0; w < n; w++) begin
        a = $urandom_range(0, 31);
        d = 8'($urandom_range(32'h21, 32'h7e));
        write_cell(a, d);
        ref_dirty[a] = 1'b1;
      end
      ready_en = 1'b1;
      exp_q.delete();
      last = ref_ptr;
      for (int k = 0; k < 32; k++) begin
        c = (ref_ptr + k) % 32;
        if (ref_dirty[c]) begin
          exp_q.push_back(ent(c, ref_buf[c]));
          last = c;
        end
      end
      ref_ptr = (last + 1) % 32;
      wait_idle(1000);
      chk($sformatf("rnd%0d_count", r), 32'(mon_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++)
        chk($sformatf("rnd%0d_ent%0d", r, k), 32'(mon_q[k]), 32'(exp_q[k]));
      mon_q.delete(); mon_t.delete();
    end

    // Busy timeout and retry
    drv_ignore = 1'b1;
    write_cell(20, 8'h5a);
    wait_pulses(2, 200);
    chk("tmo_first",  32'(mon_q[0]), 32'(ent(20, 8'h5a)));
    chk("tmo_retry",  32'(mon_q[1]), 32'(ent(20, 8'h5a)));
    chk("tmo_gap",    32'(mon_t[1] - mon_t[0]), 32'(BUSY_TIMEOUT + 2));
    repeat (3) @(negedge clk);
    drv_ignore = 1'b0;
    wait_idle(300);
    chk("tmo_total", 32'(mon_q.size()), 32'd3);
    chk("tmo_last",  32'(mon_q[2]), 32'(ent(20, 8'h5a)));
    mon_q.delete(); mon_t.delete();

    // Periodic refresh window on a clean screen
    repeat (2600) @(negedge clk);
`ifdef LCD_PERIODIC_REFRESH_EN
    chk("refresh_writes", 32'(mon_q.size() >= 32), 32'd1);
`else
    chk("refresh_none", 32'(mon_q.size()), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
